ctb_broadcast_int: RTL and testbench
====================================

CTB_BROADCAST_INT -- requirements
Module: ctb_broadcast_int

Interface
REQ-001 LANE_FIFO_DEPTH, default 4, per-lane pending-tag FIFO entries; power of two, >= 4.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  pipeline squash; discards all pending and in-flight tags.
REQ-005 fast_valid  input  ISSUE_WIDTH_INT  per-pipe single-cycle (ALU/branch) completion.
REQ-006 fast_prf_int_index  input  ISSUE_WIDTH_INT x PRF_INT_INDEX_SIZE  destination tag per fast completion.
REQ-007 slow_valid  input  ISSUE_WIDTH_INT  per-pipe multi-cycle completion (mul on pipe 1, div on pipe 2; pipe 0 tied 0 at integration).
REQ-008 slow_prf_int_index  input  ISSUE_WIDTH_INT x PRF_INT_INDEX_SIZE  destination tag per slow completion.
REQ-009 ctb_valid  output  ISSUE_WIDTH_INT  common-tag-bus lane valid, to issue queue.
REQ-010 ctb_prf_int_index  output  ISSUE_WIDTH_INT x PRF_INT_INDEX_SIZE  broadcast tag per lane.
REQ-011 ex_busy  output  ISSUE_WIDTH_INT  per-pipe issue stall, to issue queue.
REQ-012 ctb_overflow  output  1  sticky dropped-tag flag (REQ-026).

Function
REQ-013 Lane i SHALL serve pipe i only; lanes SHALL be fully independent.
REQ-014 Candidates per lane per cycle, oldest first: FIFO head, slow, fast.
REQ-015 Oldest candidate SHALL be driven on lane i's registered CTB output in the next cycle; remaining candidates SHALL be pushed in order slow then fast.
REQ-016 Latency: with FIFO empty, a lone completion in cycle N SHALL appear on ctb in cycle N+1; no combinational input-to-output path.
REQ-017 At most one tag per lane per cycle; tags SHALL pass unmodified, index 0 included.
REQ-018 ctb_valid[i] SHALL be 0 in any cycle with no candidate in the previous cycle.
REQ-019 FIFO: at most 2 pushes and 1 pop per cycle; pointers wrap modulo LANE_FIFO_DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-020 Pop and push in the same cycle SHALL be evaluated pop-first; pushes beyond resulting free space SHALL be dropped, fast dropped before slow.
REQ-021 ex_busy[i] SHALL be registered, asserted when next-cycle occupancy >= DEPTH-2, otherwise deasserted.
REQ-022 flush SHALL, in the next cycle, give ctb_valid=0, empty FIFOs, ex_busy=0; completions presented in the flush cycle SHALL be discarded.
REQ-023 flush SHALL take priority over all pushes and pops.

Reset
REQ-024 reset SHALL give ctb_valid=0, ctb_prf_int_index=0, ex_busy=0, ctb_overflow=0, FIFOs empty, pointers 0.
REQ-025 reset mid-operation SHALL discard pending tags; reset has priority over flush.

Configuration
REQ-026 CTB_OVERFLOW_CHK_EN defined: ctb_overflow SHALL set on any dropped push and clear only on reset, not on flush.
REQ-027 CTB_OVERFLOW_CHK_EN undefined: ctb_overflow tied 0, no sticky register; drop behaviour unchanged.

Structure
REQ-028 ISSUE_WIDTH_INT and PRF_INT_INDEX_SIZE SHALL come from the shared micro_op header.
REQ-029 Typedef ctb_entry_t {valid, prf_int_index} SHALL live in the shared micro_op header for reuse by the issue queue.
REQ-030 Sub-module ctb_lane_fifo (dual-push/single-pop FIFO, occupancy, busy) SHALL be instantiated ISSUE_WIDTH_INT times via generate.

Verification
REQ-031 Lane 0 fast_valid, tag 5, cycle N, FIFO empty -> ctb_valid[0]=1, tag 5 in N+1 only; ex_busy[0]=0.
REQ-032 Lane 1 slow tag 7 and fast tag 9 in cycle N -> tag 7 in N+1, tag 9 in N+2; ex_busy[1] stays 0.
REQ-033 Lane 2 slow+fast every cycle, DEPTH=4 -> ex_busy[2] asserts once occupancy reaches 2; broadcast order strictly by age, no loss while bench honours ex_busy.
REQ-034 Ignore ex_busy, keep pushing 2/cycle -> fast tags dropped after full; ctb_overflow=1 with macro, 0 without; stays set through flush.
REQ-035 Lane 1 holding 3 pending tags, flush in cycle N with new completions -> ctb_valid=0 from N+1 onward, ex_busy=0, FIFO empty.
REQ-036 reset asserted with all lanes non-empty -> next cycle all outputs 0; fresh fast tag 3 after release broadcast one cycle later.

Source files
------------

// File: rtl/ctb_broadcast_int_pkg.sv
// Shared micro-op definitions for the integer common tag bus: issue width,
// physical register tag width and the CTB entry type reused by the issue queue.
package ctb_broadcast_int_pkg;

  localparam int ISSUE_WIDTH_INT    = 3;
  localparam int PRF_INT_INDEX_SIZE = 6;

  typedef struct packed {
    logic                          valid;
    logic [PRF_INT_INDEX_SIZE-1:0] prf_int_index;
  } ctb_entry_t;

endpackage

// File: rtl/ctb_broadcast_int_lane_fifo.sv
// One CTB lane: picks the oldest of {FIFO head, slow, fast} for broadcast and
// queues the rest in a dual-push/single-pop FIFO. Drop flag exists only with CTB_OVERFLOW_CHK_EN.
module ctb_lane_fifo
  import ctb_broadcast_int_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_flush,
  input  logic                          i_slow_valid,
  input  logic [PRF_INT_INDEX_SIZE-1:0] i_slow_prf_int_index,
  input  logic                          i_fast_valid,
  input  logic [PRF_INT_INDEX_SIZE-1:0] i_fast_prf_int_index,
  output logic                          o_ctb_valid,
  output logic [PRF_INT_INDEX_SIZE-1:0] o_ctb_prf_int_index,
  output logic                          o_busy
`ifdef CTB_OVERFLOW_CHK_EN
  ,
  output logic                          o_drop
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PRF_INT_INDEX_SIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]                 r_rd_ptr;
  logic [PW-1:0]                 r_wr_ptr;
  logic [CW-1:0]                 r_count;
  ctb_entry_t                    r_out;
  logic                          r_busy;

  ctb_entry_t    w_head, w_slow, w_fast, w_sel, w_push_a, w_push_b;
  logic          w_pop, w_live, w_acc_a, w_acc_b;
  logic [CW-1:0] w_free, w_count_next;
  logic [PW-1:0] w_wr_ptr_b;

  assign w_head = {r_count != '0, r_mem[r_rd_ptr]};
  assign w_slow = {i_slow_valid, i_slow_prf_int_index};
  assign w_fast = {i_fast_valid, i_fast_prf_int_index};
  assign w_live = !i_reset && !i_flush;
  assign w_pop  = w_head.valid;

  // Age order is head, slow, fast; push_b is only ever the fast tag.
  always_comb begin
    w_sel    = '0;
    w_push_a = '0;
    w_push_b = '0;
    if (w_head.valid) begin
      w_sel = w_head;
      if (w_slow.valid) begin
        w_push_a = w_slow;
        w_push_b = w_fast;
      end else begin
        w_push_a = w_fast;
      end
    end else if (w_slow.valid) begin
      w_sel    = w_slow;
      w_push_a = w_fast;
    end else begin
      w_sel = w_fast;
    end
  end

  // Free space is taken after the pop so a full FIFO can still accept one push.
  assign w_free       = CW'(DEPTH) - r_count + CW'(w_pop);
  assign w_acc_a      = w_live && w_push_a.valid && (w_free >= CW'(1));
  assign w_acc_b      = w_live && w_push_b.valid && (w_free >= CW'(2));
  assign w_wr_ptr_b   = r_wr_ptr + PW'(1);
  assign w_count_next = r_count - CW'(w_pop) + CW'(w_acc_a) + CW'(w_acc_b);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_out    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_out <= w_sel;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_wr_ptr <= r_wr_ptr + PW'(w_acc_a) + PW'(w_acc_b);
      r_count  <= w_count_next;
      r_busy   <= w_count_next >= CW'(DEPTH - 2);
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_acc_a) r_mem[r_wr_ptr]   <= w_push_a.prf_int_index;
    if (w_acc_b) r_mem[w_wr_ptr_b] <= w_push_b.prf_int_index;
  end

  assign o_ctb_valid         = r_out.valid;
  assign o_ctb_prf_int_index = r_out.prf_int_index;
  assign o_busy              = r_busy;

`ifdef CTB_OVERFLOW_CHK_EN
  assign o_drop = w_live && ((w_push_a.valid && !w_acc_a) || (w_push_b.valid && !w_acc_b));
`endif

endmodule

// File: rtl/ctb_broadcast_int.sv
// Integer common tag bus: one independent lane per issue pipe, registered outputs.
// Optional sticky ctb_overflow flag enabled by CTB_OVERFLOW_CHK_EN.
module ctb_broadcast_int
  import ctb_broadcast_int_pkg::*;
#(
  parameter int LANE_FIFO_DEPTH = 4
) (
  input  logic                                               i_clock,
  input  logic                                               i_reset,
  input  logic                                               i_flush,
  input  logic [ISSUE_WIDTH_INT-1:0]                         i_fast_valid,
  input  logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0] i_fast_prf_int_index,
  input  logic [ISSUE_WIDTH_INT-1:0]                         i_slow_valid,
  input  logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0] i_slow_prf_int_index,
  output logic [ISSUE_WIDTH_INT-1:0]                         o_ctb_valid,
  output logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0] o_ctb_prf_int_index,
  output logic [ISSUE_WIDTH_INT-1:0]                         o_ex_busy,
  output logic                                               o_ctb_overflow
);

`ifdef CTB_OVERFLOW_CHK_EN
  logic [ISSUE_WIDTH_INT-1:0] w_drop;
`endif

  generate
    for (genvar gi = 0; gi < ISSUE_WIDTH_INT; gi++) begin : g_lane
      ctb_lane_fifo #(
        .DEPTH(LANE_FIFO_DEPTH)
      ) u_lane (
        .i_clock              (i_clock),
        .i_reset              (i_reset),
        .i_flush              (i_flush),
        .i_slow_valid         (i_slow_valid[gi]),
        .i_slow_prf_int_index (i_slow_prf_int_index[gi]),
        .i_fast_valid         (i_fast_valid[gi]),
        .i_fast_prf_int_index (i_fast_prf_int_index[gi]),
        .o_ctb_valid          (o_ctb_valid[gi]),
        .o_ctb_prf_int_index  (o_ctb_prf_int_index[gi]),
        .o_busy               (o_ex_busy[gi])
`ifdef CTB_OVERFLOW_CHK_EN
        ,
        .o_drop               (w_drop[gi])
`endif
      );
    end
  endgenerate

`ifdef CTB_OVERFLOW_CHK_EN
  // Survives flush on purpose: only reset clears evidence of a lost tag.
  logic r_overflow;
  always_ff @(posedge i_clock) begin
    if (i_reset)      r_overflow <= 1'b0;
    else if (|w_drop) r_overflow <= 1'b1;
  end
  assign o_ctb_overflow = r_overflow;
`else
  assign o_ctb_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ctb_broadcast_int.sv
// Scoreboard bench for ctb_broadcast_int: stimulus queues expected broadcasts
// (lane, tag, cycle); a negedge monitor matches them against the CTB outputs.
module tb_ctb_broadcast_int;
  import ctb_broadcast_int_pkg::*;

  localparam int NL = ISSUE_WIDTH_INT;
  localparam int W  = PRF_INT_INDEX_SIZE;
`ifdef CTB_OVERFLOW_CHK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset, flush;
  logic [NL-1:0]          fast_valid, slow_valid;
  logic [NL-1:0][W-1:0]   fast_idx, slow_idx;
  logic [NL-1:0]          ctb_valid, ex_busy;
  logic [NL-1:0][W-1:0]   ctb_idx;
  logic                   ctb_overflow;

  ctb_broadcast_int #(.LANE_FIFO_DEPTH(4)) dut (
    .i_clock              (clk),
    .i_reset              (reset),
    .i_flush              (flush),
    .i_fast_valid         (fast_valid),
    .i_fast_prf_int_index (fast_idx),
    .i_slow_valid         (slow_valid),
    .i_slow_prf_int_index (slow_idx),
    .o_ctb_valid          (ctb_valid),
    .o_ctb_prf_int_index  (ctb_idx),
    .o_ex_busy            (ex_busy),
    .o_ctb_overflow       (ctb_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int lane; int tag; int cyc; } exp_t;
  exp_t exp_q[$];
  int   last_cyc [NL];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expected entry is due on an exact cycle; anything else is unexpected.
  always @(negedge clk) begin
    int idx;
    for (int i = 0; i < NL; i++) begin
      idx = -1;
      for (int k = 0; k < exp_q.size(); k++)
        if (exp_q[k].lane == i && exp_q[k].cyc == cyc) idx = k;
      if (idx >= 0) begin
        n_checks++;
        if (ctb_valid[i] !== 1'b1 || ctb_idx[i] !== W'(exp_q[idx].tag)) begin
          $display("FAIL ctb_lane%0d cyc %0d: got valid=%b tag=%0d, expected valid=1 tag=%0d",
                   i, cyc, ctb_valid[i], ctb_idx[i], exp_q[idx].tag);
        end else begin
          n_pass++;
          $display("cyc %0d lane %0d broadcast tag %0d ok", cyc, i, exp_q[idx].tag);
        end
        exp_q.delete(idx);
      end else if (ctb_valid[i] === 1'b1) begin
        n_checks++;
        $display("FAIL ctb_lane%0d cyc %0d: got unexpected tag=%0d, expected no broadcast",
                 i, cyc, ctb_idx[i]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("cyc %0d %s = %0d ok", cyc, name, act);
    end else begin
      $display("FAIL %s cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // One broadcast per lane per cycle, in issue order, never before the next cycle.
  task automatic expect_tag(input int lane, input int tag);
    exp_t e;
    e.lane = lane;
    e.tag  = tag;
    e.cyc  = (cyc + 1 > last_cyc[lane] + 1) ? cyc + 1 : last_cyc[lane] + 1;
    last_cyc[lane] = e.cyc;
    exp_q.push_back(e);
  endtask

  task automatic discard_pending();
    for (int k = exp_q.size() - 1; k >= 0; k--)
      if (exp_q[k].cyc > cyc) exp_q.delete(k);
    for (int i = 0; i < NL; i++) last_cyc[i] = cyc + 1;
  endtask

  task automatic issue(input int lane, input bit slow, input int tag, input bit track);
    if (slow) begin
      slow_valid[lane] = 1'b1;
      slow_idx[lane]   = W'(tag);
    end else begin
      fast_valid[lane] = 1'b1;
      fast_idx[lane]   = W'(tag);
    end
    if (track) expect_tag(lane, tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    fast_valid = '0;
    slow_valid = '0;
    fast_idx   = '0;
    slow_idx   = '0;
    flush      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NL; i++) last_cyc[i] = 0;
    reset = 1'b1; flush = 1'b0;
    fast_valid = '0; slow_valid = '0; fast_idx = '0; slow_idx = '0;
    repeat (3) tick();
    check("rst_ctb_valid", 32'(ctb_valid), 0);
    check("rst_ctb_index", 32'(ctb_idx), 0);
    check("rst_ex_busy", 32'(ex_busy), 0);
    check("rst_overflow", 32'(ctb_overflow), 0);
    reset = 1'b0;
    tick();

    // Lone fast completions: lane 0 tag 5, lane 2 tag 0 (index 0 must pass).
    issue(0, 0, 5, 1);
    issue(2, 0, 0, 1);
    tick();
    check("t1_busy0", 32'(ex_busy[0]), 0);
    repeat (3) tick();

    // Lane 1 slow 7 + fast 9 together: slow first, fast one cycle later.
    issue(1, 1, 7, 1);
    issue(1, 0, 9, 1);
    tick();
    check("t2_busy1_a", 32'(ex_busy[1]), 0);
    tick();
    check("t2_busy1_b", 32'(ex_busy[1]), 0);
    repeat (3) tick();

    // Lane 2 slow+fast every cycle while honouring ex_busy.
    for (int k = 0; k < 10; k++) begin
      if (!ex_busy[2]) begin
        issue(2, 1, 20 + 2 * k, 1);
        issue(2, 0, 21 + 2 * k, 1);
      end
      tick();
      if (k == 0) check("t3_busy2_occ1", 32'(ex_busy[2]), 0);
      if (k == 1) check("t3_busy2_occ2", 32'(ex_busy[2]), 1);
    end
    repeat (6) tick();
    check("t3_busy2_drained", 32'(ex_busy[2]), 0);

    // Lane 1 ignoring ex_busy: fast tags of cycles 4 and 5 find no room.
    check("t4_overflow_before", 32'(ctb_overflow), 0);
    for (int k = 0; k < 6; k++) begin
      issue(1, 1, 40 + 2 * k, 1);
      issue(1, 0, 41 + 2 * k, k < 4);
      tick();
    end
    check("t4_overflow_after", 32'(ctb_overflow), 32'(EXP_OVF));
    repeat (6) tick();

    // Lane 1 builds 3 pending tags, then flush with fresh completions on all lanes.
    for (int k = 0; k < 3; k++) begin
      issue(1, 1, 50 + 2 * k, 1);
      issue(1, 0, 51 + 2 * k, 1);
      tick();
    end
    check("t5_busy1_prefl", 32'(ex_busy[1]), 1);
    flush = 1'b1;
    for (int i = 0; i < NL; i++) issue(i, 0, 60 + i, 0);
    issue(1, 1, 59, 0);
    discard_pending();
    tick();
    check("t5_valid_fl1", 32'(ctb_valid), 0);
    check("t5_busy_fl1", 32'(ex_busy), 0);
    tick();
    check("t5_valid_fl2", 32'(ctb_valid), 0);
    check("t5_overflow_sticky", 32'(ctb_overflow), 32'(EXP_OVF));
    issue(1, 0, 12, 1);
    tick();
    check("t5_busy1_empty", 32'(ex_busy[1]), 0);
    repeat (2) tick();

    // All lanes non-empty, then reset with completions present.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NL; i++) begin
        issue(i, 1, 10 * i + 2 * k, 1);
        issue(i, 0, 10 * i + 2 * k + 1, 1);
      end
      tick();
    end
    reset = 1'b1;
    for (int i = 0; i < NL; i++) issue(i, 0, 30 + i, 0);
    discard_pending();
    tick();
    check("t6_rst_valid", 32'(ctb_valid), 0);
    check("t6_rst_index", 32'(ctb_idx), 0);
    check("t6_rst_busy", 32'(ex_busy), 0);
    check("t6_rst_overflow", 32'(ctb_overflow), 0);
    reset = 1'b0;
    issue(0, 0, 3, 1);
    repeat (4) tick();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
